// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: memory-wait hold, timeout error, branch flush and load-use stall.
// Control outputs are combinational from state and inputs; state/counters update on the rising edge.
module pipeline_hazard_ctrl #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ID_RS1,
  input  logic [4:0]       ID_RS2,
  input  logic [4:0]       ID_EX_RD,
  input  logic             ID_EX_MemRead,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             PC_write,
  output logic             IF_ID_write,
  output logic             ID_EX_bubble,
  output logic             IF_ID_flush,
  output logic             pipe_hold,
  output logic             mem_err,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_count
);

  localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_WAIT = 2'b01,
    ST_ERR  = 2'b10
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_err_q, mem_err_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic hold_c;
  logic load_use_c;
  logic load_use_stall_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    case (state_q)
      ST_RUN: begin
        if (mem_req && !mem_ready) begin
          state_d    = ST_WAIT;
          wait_cnt_d = '0;
        end
      end
      ST_WAIT: begin
        if (mem_ready) begin
          state_d = ST_RUN;
        end else if (wait_cnt_q >= WAIT_MAX) begin
          state_d   = ST_ERR;
          mem_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      ST_ERR: begin
        mem_err_d = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Hold outranks branch and load-use: EX is frozen, so both are re-seen on release.
  always_comb begin
    hold_c = 1'b0;
    case (state_q)
      ST_RUN:  hold_c = mem_req && !mem_ready;
      ST_WAIT: hold_c = !mem_ready;
      ST_ERR:  hold_c = 1'b1;
      default: hold_c = 1'b0;
    endcase

    load_use_c = ID_EX_MemRead && (ID_EX_RD != 5'd0) &&
                 ((ID_EX_RD == ID_RS1) || (ID_EX_RD == ID_RS2));
    load_use_stall_c = !hold_c && !branch_taken && load_use_c;

    PC_write     = 1'b1;
    IF_ID_write  = 1'b1;
    ID_EX_bubble = 1'b0;
    IF_ID_flush  = 1'b0;
    pipe_hold    = 1'b0;

    if (rst) begin
      PC_write     = 1'b0;
      IF_ID_write  = 1'b0;
      ID_EX_bubble = 1'b1;
      IF_ID_flush  = 1'b1;
    end else if (hold_c) begin
      PC_write    = 1'b0;
      IF_ID_write = 1'b0;
      pipe_hold   = 1'b1;
    end else if (branch_taken) begin
      ID_EX_bubble = 1'b1;
      IF_ID_flush  = 1'b1;
    end else if (load_use_stall_c) begin
      PC_write     = 1'b0;
      IF_ID_write  = 1'b0;
      ID_EX_bubble = 1'b1;
    end

    stall_cnt_d = stall_cnt_q;
    if ((hold_c || load_use_stall_c) && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  assign mem_err     = mem_err_q;
  assign state       = state_q;
  assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios then random traffic against a rule-level model.
module tb_pipeline_hazard_ctrl;

  localparam int CW  = 4;
  localparam int TO  = 4;
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    ID_RS1, ID_RS2, ID_EX_RD;
  logic          ID_EX_MemRead, branch_taken, mem_req, mem_ready;
  logic          PC_write, IF_ID_write, ID_EX_bubble, IF_ID_flush, pipe_hold, mem_err;
  logic [1:0]    state;
  logic [CW-1:0] stall_count;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: mode 0=run, 1=waiting on memory, 2=error
  int m_mode  = 0;
  int m_wait  = 0;
  int m_stall = 0;
  int m_err   = 0;

  pipeline_hazard_ctrl #(.CNT_W(CW), .MEM_TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .ID_RS1       (ID_RS1),
    .ID_RS2       (ID_RS2),
    .ID_EX_RD     (ID_EX_RD),
    .ID_EX_MemRead(ID_EX_MemRead),
    .branch_taken (branch_taken),
    .mem_req      (mem_req),
    .mem_ready    (mem_ready),
    .PC_write     (PC_write),
    .IF_ID_write  (IF_ID_write),
    .ID_EX_bubble (ID_EX_bubble),
    .IF_ID_flush  (IF_ID_flush),
    .pipe_hold    (pipe_hold),
    .mem_err      (mem_err),
    .state        (state),
    .stall_count  (stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode  = 0;
    m_wait  = 0;
    m_stall = 0;
    m_err   = 0;
  endtask

  // One cycle: drive at negedge, check outputs just after, advance the model for the coming edge.
  task automatic step(input bit r, input int rs1, input int rs2, input int rd,
                      input bit mr, input bit br, input bit req, input bit rdy);
    bit luse, hold, ls;
    int e_pcw, e_ifw, e_bub, e_fl, e_hold;
    @(negedge clk);
    rst           = r;
    ID_RS1        = 5'(rs1);
    ID_RS2        = 5'(rs2);
    ID_EX_RD      = 5'(rd);
    ID_EX_MemRead = mr;
    branch_taken  = br;
    mem_req       = req;
    mem_ready     = rdy;
    #1;
    if (r) model_reset();
    luse = mr && (rd != 0) && (rd == rs1 || rd == rs2);
    hold = (m_mode == 2) || (m_mode == 1 && !rdy) || (m_mode == 0 && req && !rdy);
    ls   = !hold && !br && luse;
    if (r) begin
      e_pcw = 0; e_ifw = 0; e_bub = 1; e_fl = 1; e_hold = 0;
    end else begin
      e_pcw  = (!hold && !ls) ? 1 : 0;
      e_ifw  = e_pcw;
      e_bub  = (!hold && (br || ls)) ? 1 : 0;
      e_fl   = (!hold && br) ? 1 : 0;
      e_hold = hold ? 1 : 0;
    end
    chk("PC_write",     int'(PC_write),     e_pcw);
    chk("IF_ID_write",  int'(IF_ID_write),  e_ifw);
    chk("ID_EX_bubble", int'(ID_EX_bubble), e_bub);
    chk("IF_ID_flush",  int'(IF_ID_flush),  e_fl);
    chk("pipe_hold",    int'(pipe_hold),    e_hold);
    chk("mem_err",      int'(mem_err),      m_err);
    chk("state",        int'(state),        m_mode);
    chk("stall_count",  int'(stall_count),  m_stall);
    if (!r) begin
      if ((hold || ls) && m_stall < SAT) m_stall++;
      case (m_mode)
        0: if (req && !rdy) begin m_mode = 1; m_wait = 0; end
        1: begin
          if (rdy) m_mode = 0;
          else if (m_wait >= TO) begin m_mode = 2; m_err = 1; end
          else m_wait++;
        end
        default: m_err = 1;
      endcase
    end
  endtask

  task automatic idle();
    step(0, 1, 2, 3, 0, 0, 0, 1);
  endtask

  initial begin
    rst = 1'b1; ID_RS1 = '0; ID_RS2 = '0; ID_EX_RD = '0;
    ID_EX_MemRead = 1'b0; branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b1;
    #2;
    chk("rst_state",  int'(state),        0);
    chk("rst_stall",  int'(stall_count),  0);
    chk("rst_pcw",    int'(PC_write),     0);
    chk("rst_bubble", int'(ID_EX_bubble), 1);
    chk("rst_hold",   int'(pipe_hold),    0);

    step(1, 0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 1);
    idle();

    // Load-use on RS2, then forwarding covers the next cycle with no second bubble
    step(0, 3, 5, 5, 1, 0, 0, 1);
    step(0, 3, 7, 5, 0, 0, 0, 1);
    chk("luse_count", int'(stall_count), 1);

    // Load into x0 is never a hazard
    step(0, 0, 4, 0, 1, 0, 0, 1);

    // Branch taken wins over load-use and is not counted
    step(0, 6, 2, 6, 1, 1, 0, 1);
    idle();
    chk("flush_nocount", int'(stall_count), 1);

    // Three-cycle memory wait
    step(0, 1, 2, 3, 0, 0, 1, 0);
    step(0, 1, 2, 3, 0, 1, 1, 0);
    step(0, 5, 5, 5, 1, 0, 1, 0);
    chk("wait_state", int'(state), 1);
    step(0, 1, 2, 3, 0, 0, 1, 1);
    idle();
    chk("wait_count", int'(stall_count), 4);

    // Zero-wait access
    step(0, 1, 2, 3, 0, 0, 1, 1);
    idle();

    // Timeout into the sticky error state
    for (int i = 0; i < 9; i++) step(0, 1, 2, 3, 0, i[0], 1, 0);
    chk("err_state", int'(state), 2);
    chk("err_flag",  int'(mem_err), 1);
    step(0, 1, 2, 3, 0, 0, 0, 1);
    step(1, 1, 2, 3, 0, 0, 0, 1);
    idle();
    chk("err_cleared", int'(mem_err), 0);

    // Asynchronous reset in the middle of a memory wait
    step(0, 1, 2, 3, 0, 0, 1, 0);
    step(0, 1, 2, 3, 0, 0, 1, 0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_state", int'(state), 0);
    chk("async_stall", int'(stall_count), 0);
    chk("async_hold",  int'(pipe_hold), 0);
    model_reset();
    step(1, 1, 2, 3, 0, 0, 1, 0);
    idle();

    // Saturation of the stall counter
    for (int i = 0; i < SAT + 5; i++) step(0, 9, 1, 9, 1, 0, 0, 1);
    chk("sat_count", int'(stall_count), SAT);

    // Random traffic
    step(1, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 49) == 0),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
           $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 7);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
